// File: rtl/chien_search_par_pkg.sv
// Shared GF(2^M) field constants, FSM state type and the elaboration-time
// helpers that turn field constants into fixed XOR matrices.
package chien_search_par_pkg;

  localparam int          GF_M         = 13;
  localparam logic [13:0] GF_PRIM_POLY = 14'h201B;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Shift-and-add multiply in GF(2^m), reducing by poly after every shift.
  function automatic logic [31:0] gf_mul_const(input logic [31:0] a,
                                               input logic [31:0] c,
                                               input int          m    = GF_M,
                                               input logic [31:0] poly = 32'(GF_PRIM_POLY));
    logic [31:0] acc;
    logic [31:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < m; i++) begin
      if (c[i]) acc ^= x;
      x = x << 1;
      if (x[m]) x ^= poly;
    end
    return acc;
  endfunction

  // alpha^e with the exponent folded into 0..2^m-2, so negative powers work.
  function automatic logic [31:0] gf_alpha_pow(input int          e,
                                               input int          m    = GF_M,
                                               input logic [31:0] poly = 32'(GF_PRIM_POLY));
    int          n;
    int          r_e;
    logic [31:0] acc;
    logic [31:0] base;
    n   = (1 << m) - 1;
    r_e = e % n;
    if (r_e < 0) r_e += n;
    acc  = 32'd1;
    base = 32'd2;
    while (r_e > 0) begin
      if ((r_e & 1) != 0) acc = gf_mul_const(acc, base, m, poly);
      base = gf_mul_const(base, base, m, poly);
      r_e  = r_e >> 1;
    end
    return acc;
  endfunction

endpackage

// File: rtl/chien_search_par_gf_const_mul.sv
// Multiply a GF(2^M) symbol by the elaboration-time constant C; pure XOR matrix.
module gf_const_mul
  import chien_search_par_pkg::*;
#(
  parameter int          M         = GF_M,
  parameter logic [31:0] PRIM_POLY = 32'(GF_PRIM_POLY),
  parameter logic [31:0] C         = 32'd1
) (
  input  logic [M-1:0] a_i,
  output logic [M-1:0] y_o
);

  // Column b holds C * x^b; the product is the XOR of columns selected by a_i.
  function automatic logic [M*M-1:0] build_matrix();
    logic [M*M-1:0] mat;
    mat = '0;
    for (int b = 0; b < M; b++) begin
      mat[b*M +: M] = M'(gf_mul_const(32'd1 << b, C, M, PRIM_POLY));
    end
    return mat;
  endfunction

  localparam logic [M*M-1:0] MAT = build_matrix();

  always_comb begin
    y_o = '0;
    for (int b = 0; b < M; b++) begin
      if (a_i[b]) y_o ^= MAT[b*M +: M];
    end
  end

endmodule

// File: rtl/chien_search_par.sv
// P-lane parallel Chien search: evaluates the error locator at alpha^(OFFSET+pos)
// for pos = 0..N-1, P positions per enabled cycle, and reports roots per block.
module chien_search_par
  import chien_search_par_pkg::*;
#(
  parameter int         M         = GF_M,
  parameter int         T         = 8,
  parameter int         P         = 8,
  parameter int         N         = 8191,
  parameter int         OFFSET    = 1,
  parameter logic [M:0] PRIM_POLY = GF_PRIM_POLY
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 enable,
  input  logic [(T+1)*M-1:0]                   lambda,
  input  logic [$clog2(T+1)-1:0]               deg,
  output logic                                 busy,
  output logic                                 err_vld,
  output logic [P-1:0]                         err_mask,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] err_base,
  output logic                                 done,
  output logic [$clog2(T+1):0]                 err_cnt,
  output logic                                 fail
);

  localparam int              DW        = $clog2(T + 1);
  localparam int              CW        = DW + 1;
  localparam int              BW        = (N > 1) ? $clog2(N) : 1;
  localparam int              K         = (N + P - 1) / P;
  localparam logic [BW-1:0]   LAST_BASE = BW'((K - 1) * P);
  localparam logic [CW-1:0]   CNT_MAX   = '1;
  localparam logic [31:0]     POLY      = 32'(PRIM_POLY);

  state_e              state_q, state_d;
  logic [M-1:0]        r_q      [1:T];
  logic [M-1:0]        r_d      [1:T];
  logic [M-1:0]        r_load   [1:T];
  logic [M-1:0]        r_step   [1:T];
  logic [M-1:0]        term     [0:P-1][1:T];
  logic [M-1:0]        lambda0_q, lambda0_d;
  logic [DW-1:0]       deg_q, deg_d;
  logic [BW-1:0]       pos_q, pos_d;
  logic                err_vld_q, err_vld_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;
  logic [P-1:0]        err_mask_q, err_mask_d;
  logic [BW-1:0]       err_base_q, err_base_d;
  logic [CW-1:0]       err_cnt_q, err_cnt_d;
  logic [CW-1:0]       cnt_sum;
  logic [31:0]         cnt_wide;
  logic [P-1:0]        hit;
  logic [P-1:0][M-1:0] syn;

  // Per coefficient: load scaling, per-block stepping, and one product per lane.
  for (genvar j = 1; j <= T; j++) begin : g_coef
    gf_const_mul #(
      .M(M), .PRIM_POLY(POLY), .C(gf_alpha_pow(j * OFFSET, M, POLY))
    ) u_load (
      .a_i(lambda[j*M +: M]),
      .y_o(r_load[j])
    );

    gf_const_mul #(
      .M(M), .PRIM_POLY(POLY), .C(gf_alpha_pow(j * P, M, POLY))
    ) u_step (
      .a_i(r_q[j]),
      .y_o(r_step[j])
    );

    for (genvar i = 0; i < P; i++) begin : g_lane
      gf_const_mul #(
        .M(M), .PRIM_POLY(POLY), .C(gf_alpha_pow(j * i, M, POLY))
      ) u_term (
        .a_i(r_q[j]),
        .y_o(term[i][j])
      );
    end
  end

  // Lanes past position N-1 in the final block are padding and never report.
  always_comb begin
    syn = '0;
    hit = '0;
    for (int i = 0; i < P; i++) begin
      syn[i] = lambda0_q;
      for (int j = 1; j <= T; j++) syn[i] ^= term[i][j];
      hit[i] = (syn[i] == '0) && ((32'(pos_q) + 32'(i)) < 32'(N));
    end
  end

  always_comb begin
    cnt_wide = 32'(err_cnt_q) + 32'($countones(hit));
    cnt_sum  = (cnt_wide > 32'(CNT_MAX)) ? CNT_MAX : cnt_wide[CW-1:0];
  end

  // NOTE: every signal gets its hold value before the case so no path leaves
  // one unassigned; a missed default here would infer a latch.
  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    lambda0_d  = lambda0_q;
    deg_d      = deg_q;
    pos_d      = pos_q;
    err_vld_d  = err_vld_q;
    done_d     = done_q;
    fail_d     = fail_q;
    err_mask_d = err_mask_q;
    err_base_d = err_base_q;
    err_cnt_d  = err_cnt_q;

    if (enable) begin
      err_vld_d = 1'b0;
      done_d    = 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            r_d       = r_load;
            lambda0_d = lambda[M-1:0];
            deg_d     = deg;
            pos_d     = '0;
            err_cnt_d = '0;
            fail_d    = 1'b0;
            state_d   = RUN;
          end
        end
        RUN: begin
          r_d        = r_step;
          err_mask_d = hit;
          err_base_d = pos_q;
          err_vld_d  = 1'b1;
          err_cnt_d  = cnt_sum;
          pos_d      = pos_q + BW'(P);
          if (pos_q == LAST_BASE) begin
            done_d  = 1'b1;
            fail_d  = (32'(deg_q) > 32'(T)) || (32'(cnt_sum) != 32'(deg_q));
            pos_d   = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  // NOTE: the coefficient array is only T words of flops, not a RAM, so it is
  // cleared by the asynchronous reset like every other register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      for (int j = 1; j <= T; j++) r_q[j] <= '0;
      lambda0_q  <= '0;
      deg_q      <= '0;
      pos_q      <= '0;
      err_vld_q  <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      err_mask_q <= '0;
      err_base_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      lambda0_q  <= lambda0_d;
      deg_q      <= deg_d;
      pos_q      <= pos_d;
      err_vld_q  <= err_vld_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      err_mask_q <= err_mask_d;
      err_base_q <= err_base_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // A result that lands while stalled is held and presented once enable returns.
  assign busy     = (state_q == RUN);
  assign err_vld  = err_vld_q & enable;
  assign done     = done_q & enable;
  assign err_mask = err_mask_q;
  assign err_base = err_base_q;
  assign err_cnt  = err_cnt_q;
  assign fail     = fail_q;

endmodule

// File: tb/tb_chien_search_par.sv
// Self-checking bench for chien_search_par: table-driven locators, stall and
// abort sequences, and random locators against a log/antilog evaluation model.
module tb_chien_search_par;

  localparam int M      = 13;
  localparam int T      = 8;
  localparam int P      = 8;
  localparam int N      = 8191;
  localparam int OFFSET = 1;
  localparam int K      = (N + P - 1) / P;
  localparam int NQ     = (1 << M) - 1;
  localparam int STALL  = 5;

  logic                 clk    = 1'b0;
  logic                 reset  = 1'b0;
  logic                 start  = 1'b0;
  logic                 enable = 1'b0;
  logic [(T+1)*M-1:0]   lambda = '0;
  logic [3:0]           deg    = '0;
  logic                 busy, err_vld, done, fail;
  logic [P-1:0]         err_mask;
  logic [12:0]          err_base;
  logic [4:0]           err_cnt;

  chien_search_par #(
    .M(M), .T(T), .P(P), .N(N), .OFFSET(OFFSET), .PRIM_POLY(14'h201B)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .enable(enable),
    .lambda(lambda), .deg(deg), .busy(busy), .err_vld(err_vld),
    .err_mask(err_mask), .err_base(err_base), .done(done),
    .err_cnt(err_cnt), .fail(fail)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- GF reference model ----------------
  int gexp [0:NQ-1];
  int glog [0:NQ];
  int coef [0:T];
  logic [P-1:0] exp_mask [0:K-1];
  int exp_roots;

  task automatic build_tables();
    int v;
    v = 1;
    for (int e = 0; e < NQ; e++) begin
      gexp[e] = v;
      glog[v] = e;
      v = v << 1;
      if ((v & (1 << M)) != 0) v = v ^ 'h201B;
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[(glog[a] + glog[b]) % NQ];
  endfunction

  // Locator = product of (1 + beta^-1 x) with beta = alpha^(OFFSET+pos).
  task automatic coef_from_roots(input int roots[$]);
    int inv;
    for (int j = 0; j <= T; j++) coef[j] = 0;
    coef[0] = 1;
    foreach (roots[r]) begin
      inv = gexp[(NQ - ((OFFSET + roots[r]) % NQ)) % NQ];
      for (int j = T; j >= 1; j--) coef[j] = coef[j] ^ gmul(coef[j-1], inv);
    end
  endtask

  // Horner evaluation of the locator at every searched position.
  task automatic model_search();
    int x;
    int acc;
    exp_roots = 0;
    for (int k = 0; k < K; k++) exp_mask[k] = '0;
    for (int pos = 0; pos < N; pos++) begin
      x   = gexp[(OFFSET + pos) % NQ];
      acc = 0;
      for (int j = T; j >= 0; j--) acc = gmul(acc, x) ^ coef[j];
      if (acc == 0) begin
        exp_mask[pos / P][pos % P] = 1'b1;
        exp_roots++;
      end
    end
  endtask

  function automatic logic [(T+1)*M-1:0] pack_coef();
    logic [(T+1)*M-1:0] v;
    v = '0;
    for (int j = 0; j <= T; j++) v[j*M +: M] = 13'(coef[j]);
    return v;
  endfunction

  // ---------------- search driver / observer ----------------
  logic [P-1:0] obs_mask [0:K-1];
  int   n_vld, first_vld, done_cyc, busy_cnt, first_busy, base_err, done_no_vld;
  logic [4:0] cnt_at_done, cnt_hold;
  logic fail_at_done, fail_hold;

  task automatic run_search(input int dg, input int exp_cnt, input bit exp_fail,
                            input int stall_at, input int reset_at, input string tag);
    logic [(T+1)*M-1:0] lam_vec;
    logic [127:0]       junk;
    int                 quiet;
    int                 mism;
    int                 stall_len;
    bit                 finished;
    lam_vec = pack_coef();
    model_search();
    n_vld = 0; first_vld = -1; done_cyc = -1; busy_cnt = 0; first_busy = -1;
    base_err = 0; done_no_vld = 0; finished = 1'b0;
    cnt_at_done = 'x; cnt_hold = 'x; fail_at_done = 1'bx; fail_hold = 1'bx;
    for (int k = 0; k < K; k++) obs_mask[k] = '0;
    stall_len = (stall_at >= 0) ? STALL : 0;

    for (int cyc = 0; cyc < K + STALL + 20; cyc++) begin
      junk   = {$urandom(), $urandom(), $urandom(), $urandom()};
      start  = (cyc == 0) || (cyc == 50);
      enable = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + STALL);
      lambda = (cyc == 0) ? lam_vec : junk[(T+1)*M-1:0];
      deg    = (cyc == 0) ? 4'(dg) : 4'($urandom_range(0, 15));
      if (cyc == reset_at) begin
        reset = 1'b0;
        #1;
        check({tag, "_reset_outputs"},
              {busy, err_vld, err_mask, err_base, done, err_cnt, fail}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b1;
        start  = 1'b0;
        enable = 1'b1;
        quiet  = 0;
        repeat (30) begin
          @(negedge clk);
          if (busy || err_vld || done) quiet++;
        end
        check({tag, "_post_reset_quiet"}, quiet, 0);
        @(posedge clk);
        #1;
        return;
      end
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = cyc;
      end
      if (err_vld) begin
        if (first_vld < 0) first_vld = cyc;
        if (n_vld < K) obs_mask[n_vld] = err_mask;
        if (int'(err_base) != n_vld * P) base_err++;
        n_vld++;
      end
      if (done) begin
        if (!err_vld) done_no_vld++;
        if (done_cyc < 0) begin
          done_cyc     = cyc;
          cnt_at_done  = err_cnt;
          fail_at_done = fail;
        end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 3) begin
        cnt_hold  = err_cnt;
        fail_hold = fail;
        finished  = 1'b1;
      end
      @(posedge clk);
      #1;
      if (finished) break;
    end
    start  = 1'b0;
    enable = 1'b1;

    mism = 0;
    for (int k = 0; k < K; k++) if (obs_mask[k] !== exp_mask[k]) mism++;
    check({tag, "_vld_count"},    n_vld,        K);
    check({tag, "_first_vld"},    first_vld,    2);
    check({tag, "_done_cycle"},   done_cyc,     1 + K + stall_len);
    check({tag, "_busy_cycles"},  busy_cnt,     K + stall_len);
    check({tag, "_first_busy"},   first_busy,   1);
    check({tag, "_base_errs"},    base_err,     0);
    check({tag, "_done_no_vld"},  done_no_vld,  0);
    check({tag, "_mask_errs"},    mism,         0);
    check({tag, "_err_cnt"},      cnt_at_done,  exp_cnt);
    check({tag, "_fail"},         fail_at_done, exp_fail);
    check({tag, "_cnt_hold"},     cnt_hold,     exp_cnt);
    check({tag, "_fail_hold"},    fail_hold,    exp_fail);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [1:0]  nroots;
    logic [12:0] r0, r1, r2;
    logic        zero;
    logic [3:0]  dg;
    logic [4:0]  cnt;
    logic        fl;
    logic [7:0]  b0;
    logic [7:0]  last;
  } case_t;

  function automatic case_t mk(input int nr, input int r0, input int r1, input int r2,
                               input bit z, input int dg, input int cnt, input bit fl,
                               input int b0, input int last);
    case_t c;
    c.nroots = 2'(nr);
    c.r0 = 13'(r0); c.r1 = 13'(r1); c.r2 = 13'(r2);
    c.zero = z; c.dg = 4'(dg); c.cnt = 5'(cnt); c.fl = fl;
    c.b0 = 8'(b0); c.last = 8'(last);
    return c;
  endfunction

  case_t tbl [0:6];
  int    rq [$];

  initial begin
    int nr, dg, ecnt;
    bit efail;

    build_tables();
    repeat (2) @(posedge clk);
    #1;
    check("por_outputs", {busy, err_vld, err_mask, err_base, done, err_cnt, fail}, 64'd0);
    reset  = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1;

    //            nr  r0    r1    r2    zero dg cnt fail b0    last
    tbl[0] = mk(0, 0,    0,    0,    0,   0, 0,  0,   'h00, 'h00);
    tbl[1] = mk(1, 5,    0,    0,    0,   1, 1,  0,   'h20, 'h00);
    tbl[2] = mk(2, 8190, 0,    0,    0,   2, 2,  0,   'h01, 'h40);
    tbl[3] = mk(2, 8190, 0,    0,    0,   3, 2,  1,   'h01, 'h40);
    tbl[4] = mk(2, 8190, 0,    0,    0,   9, 2,  1,   'h01, 'h40);
    tbl[5] = mk(3, 100,  4000, 8189, 0,   3, 3,  0,   'h00, 'h20);
    tbl[6] = mk(0, 0,    0,    0,    1,   0, 31, 1,   'hFF, 'h7F);

    for (int i = 0; i < 7; i++) begin
      rq = {};
      if (tbl[i].nroots > 0) rq.push_back(int'(tbl[i].r0));
      if (tbl[i].nroots > 1) rq.push_back(int'(tbl[i].r1));
      if (tbl[i].nroots > 2) rq.push_back(int'(tbl[i].r2));
      if (tbl[i].zero) begin
        for (int j = 0; j <= T; j++) coef[j] = 0;
      end else begin
        coef_from_roots(rq);
      end
      run_search(int'(tbl[i].dg), int'(tbl[i].cnt), tbl[i].fl, -1, -1, $sformatf("c%0d", i));
      check($sformatf("c%0d_blk0_mask", i), obs_mask[0],   tbl[i].b0);
      check($sformatf("c%0d_last_mask", i), obs_mask[K-1], tbl[i].last);
    end

    // Five-cycle stall mid-run: same block sequence, done five cycles later.
    rq = {5, 4000};
    coef_from_roots(rq);
    run_search(2, 2, 1'b0, 400, -1, "stall");

    // Reset during block 300 aborts; a fresh search afterwards runs normally.
    rq = {5, 6000};
    coef_from_roots(rq);
    run_search(2, 2, 1'b0, -1, 301, "abort");
    run_search(2, 2, 1'b0, -1, -1, "fresh");

    // Random root sets, sometimes with a deliberately wrong degree.
    for (int it = 0; it < 3; it++) begin
      nr = $urandom_range(1, T);
      rq = {};
      for (int r = 0; r < nr; r++) rq.push_back($urandom_range(0, N - 1));
      coef_from_roots(rq);
      dg = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : nr;
      model_search();
      ecnt  = (exp_roots > 31) ? 31 : exp_roots;
      efail = (dg > T) || (ecnt != dg);
      run_search(dg, ecnt, efail, -1, -1, $sformatf("rnd%0d", it));
    end

    // Fully random coefficients.
    for (int j = 0; j <= T; j++) coef[j] = $urandom_range(0, NQ);
    dg = $urandom_range(0, 15);
    model_search();
    ecnt  = (exp_roots > 31) ? 31 : exp_roots;
    efail = (dg > T) || (ecnt != dg);
    run_search(dg, ecnt, efail, -1, -1, "rcoef");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
